// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: writeback-source and load funct3
// codes, plus the MEM/WB control bundle used by the writeback stage.
package rv32i_pkg;

    localparam logic [1:0] WB_SRC_ALU = 2'b00;
    localparam logic [1:0] WB_SRC_MEM = 2'b01;
    localparam logic [1:0] WB_SRC_PC4 = 2'b10;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b100;
    localparam logic [2:0] LD_HU = 3'b101;

    // Width-independent part of the MEM/WB register; the XLEN-wide
    // fields (alures, pcinc, dmraw) live beside it in the stage.
    typedef struct packed {
        logic       valid;
        logic       ruwr;
        logic [4:0] rd;
        logic [1:0] src;
        logic [2:0] dmctrl;
    } memwb_t;

endpackage

// File: rtl/wb_stage_load_extend.sv
// load_extend: picks the byte/halfword at the given offset from the raw
// data-memory word and sign/zero extends it according to the load funct3.
// Ports: raw_i (raw word), off_i (byte offset), funct3_i, data_o.
module load_extend
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_i[7:0];
        case (off_i)
            2'd0: byte_sel = raw_i[7:0];
            2'd1: byte_sel = raw_i[15:8];
            2'd2: byte_sel = raw_i[23:16];
            2'd3: byte_sel = raw_i[31:24];
            default: byte_sel = raw_i[7:0];
        endcase
        // Only off_i[1] matters: a misaligned halfword is not trapped.
        half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    end

    always_comb begin
        data_o = raw_i;
        case (funct3_i)
            LD_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LD_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
            LD_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            LD_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
            LD_W:    data_o = raw_i;
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, load extraction, writeback source
// select and register-file write port (RUWr/Rd/DataWr), plus retirement.
// Inputs: clk, rst (async high), Stall, Flush, Mem* bundle, DMDataRd.
// Outputs: RUWr, Rd, DataWr, WbValid, Retired, and InstRet (64-bit
// retired count) only when WB_INSTRET_EN is defined.
module wb_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    input  logic            Flush,
    input  logic            MemValid,
    input  logic            MemRUWr,
    input  logic [4:0]      MemRd,
    input  logic [1:0]      MemRUDataWrSrc,
    input  logic [XLEN-1:0] MemALURes,
    input  logic [XLEN-1:0] MemPCInc,
    input  logic [2:0]      MemDMCtrl,
    input  logic [XLEN-1:0] DMDataRd,
    output logic            RUWr,
    output logic [4:0]      Rd,
    output logic [XLEN-1:0] DataWr,
    output logic            WbValid,
`ifdef WB_INSTRET_EN
    output logic [63:0]     InstRet,
`endif
    output logic            Retired
);

    memwb_t          ctrl_q, ctrl_d;
    logic [XLEN-1:0] alures_q, alures_d;
    logic [XLEN-1:0] pcinc_q, pcinc_d;
    logic [XLEN-1:0] dmraw_q, dmraw_d;
    logic [XLEN-1:0] ld_data;

    // Flush still loads the payload; only valid is forced low.
    always_comb begin
        ctrl_d   = ctrl_q;
        alures_d = alures_q;
        pcinc_d  = pcinc_q;
        dmraw_d  = dmraw_q;
        if (Flush || !Stall) begin
            ctrl_d.valid  = MemValid & ~Flush;
            ctrl_d.ruwr   = MemRUWr;
            ctrl_d.rd     = MemRd;
            ctrl_d.src    = MemRUDataWrSrc;
            ctrl_d.dmctrl = MemDMCtrl;
            alures_d      = MemALURes;
            pcinc_d       = MemPCInc;
            dmraw_d       = DMDataRd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            alures_q <= '0;
            pcinc_q  <= '0;
            dmraw_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            alures_q <= alures_d;
            pcinc_q  <= pcinc_d;
            dmraw_q  <= dmraw_d;
        end
    end

    load_extend #(.XLEN(XLEN)) u_ld (
        .raw_i    (dmraw_q),
        .off_i    (alures_q[1:0]),
        .funct3_i (ctrl_q.dmctrl),
        .data_o   (ld_data)
    );

    always_comb begin
        DataWr = alures_q;
        case (ctrl_q.src)
            WB_SRC_MEM: DataWr = ld_data;
            WB_SRC_PC4: DataWr = pcinc_q;
            default:    DataWr = alures_q;
        endcase
    end

    assign RUWr    = ctrl_q.valid & ctrl_q.ruwr & (ctrl_q.rd != 5'd0);
    assign Rd      = ctrl_q.rd;
    assign WbValid = ctrl_q.valid;
    // The WB instruction leaves on any edge that is not a pure stall.
    assign Retired = ctrl_q.valid & (~Stall | Flush);

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    assign instret_d = instret_q + 64'(Retired);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign InstRet = instret_q;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the pipelined RV32I core and the sole writer of `RegistersUnit`. It holds the MEM/WB pipeline register and extracts and extends load data. It selects the writeback source and drives the register file write port (`RUWr`, `Rd`, `DataWr`). It also reports instruction retirement.

## Interface

- Reset: one clock; reset is asynchronous and active-high.
- Parameters:
  - `XLEN`, default 32: datapath width.
- Ports (name, direction, width, meaning):
  - `clk` in 1: core clock, rising edge.
  - `rst` in 1: asynchronous, active-high reset.
  - `Stall` in 1: hold the MEM/WB register.
  - `Flush` in 1: load a bubble into MEM/WB.
  - `MemValid` in 1: MEM stage holds a real instruction.
  - `MemRUWr` in 1: the instruction writes a register.
  - `MemRd` in 5: destination register.
  - `MemRUDataWrSrc` in 2: writeback source.
    - 00: ALU result.
    - 01: load data.
    - 10: PC+4.
    - 11: reserved, selects the ALU result.
  - `MemALURes` in XLEN: ALU result; also the effective address.
  - `MemPCInc` in XLEN: PC+4 of the instruction.
  - `MemDMCtrl` in 3: load funct3.
  - `DMDataRd` in XLEN: raw aligned word from data memory, valid in the MEM cycle.
  - `RUWr` out 1: register file write enable.
  - `Rd` out 5: register file write address.
  - `DataWr` out XLEN: register file write data.
  - `WbValid` out 1: WB holds a real instruction.
  - `Retired` out 1: one-cycle pulse when the WB instruction leaves the stage.
  - `InstRet` out 64: retired instruction count; present only with `WB_INSTRET_EN`.

## Operation

- MEM/WB register fields: `valid`, `ruwr`, `rd`, `src`, `alures`, `pcinc`, `dmctrl`, `dmraw`.
- Register update at `posedge clk`, in priority order:
  - `Flush`: `valid` <= 0; the other fields may load freely.
  - Else `Stall`: all fields hold.
  - Else: all fields load from the `Mem*` inputs and `DMDataRd`.
- `Flush` and `Stall` asserted together: the flush wins.
- `RUWr` = `valid & ruwr & (rd != 0)`. A write to x0 is never asserted.
- `Rd` = `rd`. `WbValid` = `valid`.
- Load extraction uses `alures[1:0]` as the byte offset:
  - 000 LB: byte at the offset, sign-extended.
  - 100 LBU: byte at the offset, zero-extended.
  - 001 LH: halfword selected by `alures[1]`, sign-extended.
  - 101 LHU: halfword selected by `alures[1]`, zero-extended.
  - 010 LW: the full word.
  - 011, 110, 111: the raw word, unmodified.
  - Misalignment is not checked: LH with offset 3 uses the upper halfword.
- `DataWr` is selected by `src` (ALU result, extracted load data, or `pcinc`). It is combinational from the register only; no input bypasses the register.
- While stalled, the held instruction keeps driving `RUWr`. Repeated writes of the same value are idempotent.
- `Retired` = `valid & (~Stall | Flush)`. An instruction retires exactly once, on the cycle it leaves WB.

## Timing

- Latency: one cycle from MEM inputs to the regfile write-port outputs. The regfile commits the write on the following rising edge.
- Reset values: `valid`=0, all fields 0. Hence `RUWr`=0, `Rd`=0, `DataWr`=0, `WbValid`=0, `Retired`=0, `InstRet`=0.
- Reset asserted mid-operation clears the in-flight instruction immediately and asynchronously. No write or retire is issued for it.
- First instruction after reset release: captured on the first non-stalled edge with `rst` low.

## Configuration

- `WB_INSTRET_EN` defined:
  - A 64-bit `InstRet` counter increments by 1 on each clock where `Retired`=1.
  - It wraps from 2^64-1 to 0 and is cleared by `rst`.
  - The port exists.
- `WB_INSTRET_EN` undefined: no counter and no `InstRet` port. All other behaviour is identical.

## Structure

- Shared package `rv32i_pkg`:
  - Writeback-source constants `WB_SRC_ALU`, `WB_SRC_MEM`, `WB_SRC_PC4`.
  - Load funct3 constants `LD_B`, `LD_H`, `LD_W`, `LD_BU`, `LD_HU`.
  - A `memwb_t` packed struct for the pipeline register.
- One sub-module: `load_extend`, a combinational block taking (raw word, offset, funct3) and returning the extended data.

## Test plan

- Reset mid-run:
  - Stimulus: a valid ALU write to x5 = 0x12345678 is in WB; assert `rst`.
  - Required response: `RUWr`, `DataWr` and `WbValid` drop to 0 immediately, before the next edge.
- ALU writeback:
  - Stimulus: MEM presents valid, `MemRd`=1, src 00, `MemALURes`=0xDEADBEEF.
  - Required response: next cycle `RUWr`=1, `Rd`=1, `DataWr`=0xDEADBEEF, `Retired`=1; `RURs1` reads 0xDEADBEEF from x1 afterwards.
- Load extension:
  - Stimulus: `DMDataRd`=0x80F0_7F81.
  - Required response:
    - LB at offset 0 gives 0xFFFFFF81.
    - LBU at offset 1 gives 0x0000007F.
    - LH at offset 2 gives 0xFFFF80F0.
    - LHU at offset 2 gives 0x000080F0.
    - LW gives 0x80F07F81.
- x0 and PC+4:
  - Stimulus: JAL with `MemRd`=0, src 10.
  - Required response: `RUWr`=0 and `Retired`=1.
  - Stimulus: the same instruction with `MemRd`=31.
  - Required response: `DataWr`=`MemPCInc`.
- Stall and flush:
  - Stimulus: hold `Stall` for 3 cycles with an instruction in WB.
  - Required response: outputs stable for 3 cycles, `Retired`=0 until release, then a single pulse.
  - Stimulus: `Stall` and `Flush` together.
  - Required response: a bubble is loaded and the WB instruction retires once.
- InstRet (`WB_INSTRET_EN` defined):
  - Stimulus: 10 valid instructions and 3 bubbles.
  - Required response: `InstRet`=10.
